// File: rtl/simon128_256_decrypt.sv
// simon128_256_decrypt
//   Simon128/256 block decryption core. Accepts a ciphertext block, runs the
//   72 inverse rounds from round ROUNDS-1 down to 0 and returns the plaintext.
//   Round keys are fetched one at a time over the key_schedule read port.
//   Only one read is outstanding at any time.
//
// Ports
//   clk            cfg-domain clock, rising edge
//   rst            asynchronous active-low reset
//   key_addr       round-key index requested (registered)
//   key_rd_en      one-cycle read strobe to key_schedule
//   key_data       round key returned
//   key_data_vld   qualifies key_data for the outstanding read
//   key_invalidate pulse when the key schedule is recomputed
//   s_tdata/s_tvalid/s_tready   ciphertext stream, [127:64]=x, [63:0]=y
//   m_tdata/m_tvalid/m_tready   plaintext stream,  [127:64]=x, [63:0]=y
//
// Build option
//   SIMON_DEC_KEY_CACHE_EN  keeps a local copy of the round keys. Once a full
//   schedule has been fetched, later blocks run one round per cycle from the
//   copy. key_invalidate discards the copy. Without the macro key_invalidate
//   is unused and every block fetches its keys.

module simon128_256_decrypt #(
  parameter int ROUNDS         = 72,
  parameter int KEY_ADDR_WIDTH = 9,
  parameter int WORD_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [KEY_ADDR_WIDTH-1:0] key_addr,
  output logic                      key_rd_en,
  input  logic [WORD_WIDTH-1:0]     key_data,
  input  logic                      key_data_vld,
  input  logic                      key_invalidate,
  input  logic [2*WORD_WIDTH-1:0]   s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [2*WORD_WIDTH-1:0]   m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    ITER = 3'd4
  } state_t;

  function automatic logic [WORD_WIDTH-1:0] rotl(input logic [WORD_WIDTH-1:0] a,
                                                 input int n);
    return (a << n) | (a >> (WORD_WIDTH - n));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] simon_f(input logic [WORD_WIDTH-1:0] a);
    return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
  endfunction

  // Inverse round: returns {x_next, y_next}.
  function automatic logic [2*WORD_WIDTH-1:0] inv_round(input logic [WORD_WIDTH-1:0] x,
                                                        input logic [WORD_WIDTH-1:0] y,
                                                        input logic [WORD_WIDTH-1:0] k);
    return {y, x ^ simon_f(y) ^ k};
  endfunction

  state_t                    state_q, state_d;
  logic [RW-1:0]             r_q, r_d;
  logic                      key_rd_en_q, key_rd_en_d;
  logic [KEY_ADDR_WIDTH-1:0] key_addr_q, key_addr_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic [2*WORD_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [WORD_WIDTH-1:0]     x_q, x_d, y_q, y_d;

`ifdef SIMON_DEC_KEY_CACHE_EN
  logic [WORD_WIDTH-1:0]     cache_q [ROUNDS];
  logic                      cache_we;
  logic                      cache_valid_q, cache_valid_d;
  // Cleared by key_invalidate during a fetch run so a half-stale schedule
  // is never marked valid.
  logic                      fill_ok_q, fill_ok_d;
`else
  logic                      unused_key_invalidate;
  assign unused_key_invalidate = key_invalidate;
`endif

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    key_addr_d  = key_addr_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    x_d         = x_q;
    y_d         = y_q;
    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          x_d = s_tdata[2*WORD_WIDTH-1:WORD_WIDTH];
          y_d = s_tdata[WORD_WIDTH-1:0];
          r_d = LAST_ROUND;
`ifdef SIMON_DEC_KEY_CACHE_EN
          state_d = (cache_valid_q && !key_invalidate) ? ITER : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (key_data_vld) begin
          {x_d, y_d} = inv_round(x_q, y_q, key_data);
          if (r_q == '0) begin
            state_d = OUT;
          end else begin
            r_d     = r_q - 1'b1;
            state_d = REQ;
          end
        end
      end
`ifdef SIMON_DEC_KEY_CACHE_EN
      ITER: begin
        {x_d, y_d} = inv_round(x_q, y_q, cache_q[r_q]);
        if (r_q == '0) begin
          state_d = OUT;
        end else begin
          r_d = r_q - 1'b1;
        end
      end
`endif
      OUT: begin
        // First OUT cycle loads the output register; afterwards hold it
        // until the sink takes it.
        if (!m_tvalid_q) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {x_q, y_q};
        end else if (m_tready) begin
          m_tvalid_d = 1'b0;
          r_d        = LAST_ROUND;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    key_rd_en_d = (state_d == REQ);
    if (state_d == REQ) begin
      key_addr_d = {{(KEY_ADDR_WIDTH-RW){1'b0}}, r_d};
    end
  end

`ifdef SIMON_DEC_KEY_CACHE_EN
  assign cache_we = (state_q == WAIT) && key_data_vld;

  always_comb begin
    cache_valid_d = cache_valid_q;
    fill_ok_d     = fill_ok_q;
    if ((state_q == IDLE) && s_tvalid) fill_ok_d = 1'b1;
    if (cache_we && (r_q == '0) && fill_ok_q) cache_valid_d = 1'b1;
    if (key_invalidate) begin
      cache_valid_d = 1'b0;
      fill_ok_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      fill_ok_q     <= 1'b0;
    end else begin
      cache_valid_q <= cache_valid_d;
      fill_ok_q     <= fill_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) cache_q[r_q] <= key_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      r_q         <= LAST_ROUND;
      key_rd_en_q <= 1'b0;
      key_addr_q  <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      key_rd_en_q <= key_rd_en_d;
      key_addr_q  <= key_addr_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
    end
  end

  // Working block state carries no reset; it is always loaded on accept.
  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign s_tready  = (state_q == IDLE);
  assign key_rd_en = key_rd_en_q;
  assign key_addr  = key_addr_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;

endmodule

// File: tb/tb_simon128_256_decrypt.sv
module tb_simon128_256_decrypt;
  localparam int ROUNDS = 72;
  localparam int KAW    = 9;
  localparam int W      = 64;
  localparam logic [127:0] CT0 = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
  localparam logic [127:0] PT0 = 128'h74206e69206d6f6f_6d69732061207369;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [KAW-1:0] key_addr;
  logic           key_rd_en;
  logic [W-1:0]   key_data = '0;
  logic           key_data_vld = 1'b0;
  logic           key_invalidate = 1'b0;
  logic [127:0]   s_tdata = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [127:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b0;

  simon128_256_decrypt #(.ROUNDS(ROUNDS), .KEY_ADDR_WIDTH(KAW), .WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .key_addr(key_addr), .key_rd_en(key_rd_en),
    .key_data(key_data), .key_data_vld(key_data_vld),
    .key_invalidate(key_invalidate),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rk [ROUNDS];

  // key RAM responder controls and observations
  bit lat_rand  = 1'b0;
  bit spur_en   = 1'b0;
  int fixed_lat = 1;
  int rd_count  = 0;
  int addr_bad  = 0;
  int pulse_bad = 0;

  typedef struct packed {
    logic [127:0] ct;
    logic [127:0] pt;
    logic         rnd_lat;
    logic         spur;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [63:0] rotl(input logic [63:0] a, input int n);
    return (a << n) | (a >> (64 - n));
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] a, input int n);
    return (a >> n) | (a << (64 - n));
  endfunction
  function automatic logic [63:0] sf(input logic [63:0] a);
    return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < ROUNDS; i++) begin
      t = x;
      x = y ^ sf(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"},  128'(m_tvalid),  128'd0);
    chk({tag, "_m_tdata"},   m_tdata,         128'd0);
    chk({tag, "_key_rd_en"}, 128'(key_rd_en), 128'd0);
    chk({tag, "_key_addr"},  128'(key_addr),  128'd0);
    chk({tag, "_s_tready"},  128'(s_tready),  128'd1);
  endtask

  // Key RAM model: answers each read after a fixed or random latency and
  // optionally injects stray key_data_vld pulses while no read is pending.
  initial begin : key_ram
    logic [KAW-1:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (key_rd_en === 1'b1) begin
        a = key_addr;
        if (a !== KAW'(ROUNDS - 1 - rd_count)) addr_bad++;
        rd_count++;
        lat = lat_rand ? int'($urandom_range(1, 6)) : fixed_lat;
        if (spur_en && ($urandom_range(0, 1) == 1)) begin
          key_data     = {$urandom, $urandom};
          key_data_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        key_data_vld = 1'b0;
        if (key_rd_en !== 1'b0) pulse_bad++;
        repeat (lat - 1) begin
          @(posedge clk);
          #1;
        end
        key_data     = (a < KAW'(ROUNDS)) ? rk[a] : '0;
        key_data_vld = 1'b1;
        @(posedge clk);
        #1;
        key_data_vld = 1'b0;
        key_data     = {$urandom, $urandom};
      end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
        key_data     = {$urandom, $urandom};
        key_data_vld = 1'b1;
        @(posedge clk);
        #1;
        key_data_vld = 1'b0;
      end
    end
  end

  task automatic send_block(input logic [127:0] ct);
    bit ok;
    rd_count  = 0;
    addr_bad  = 0;
    pulse_bad = 0;
    ok = 1'b0;
    @(negedge clk);
    s_tdata  = ct;
    s_tvalid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (s_tready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_tready=0 for 2000 cycles expected 1");
    end else begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until m_tvalid is seen.
  task automatic wait_output(output int cyc);
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_tvalid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL output_timeout: got m_tvalid=0 for %0d cycles expected 1", cyc);
    end
  endtask

  task automatic handshake(input string name);
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    chk({name, "_tvalid_drop"}, 128'(m_tvalid), 128'd0);
  endtask

  task automatic run_block(input string name, input logic [127:0] ct,
                           input logic [127:0] pt, output int cyc);
    send_block(ct);
    wait_output(cyc);
    chk({name, "_data"}, m_tdata, pt);
    handshake(name);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [61:0]  zseq;
    logic [63:0]  tmp;
    logic [127:0] pt;
    int cyc;
    int bad;

    // Simon128/256 key expansion (z4 sequence, bit j = z4[j])
    zseq  = 62'b11110111001001010011000011101000000100011011010110011110001011;
    rk[0] = 64'h0706050403020100;
    rk[1] = 64'h0f0e0d0c0b0a0908;
    rk[2] = 64'h1716151413121110;
    rk[3] = 64'h1f1e1d1c1b1a1918;
    for (int i = 4; i < ROUNDS; i++) begin
      tmp   = rotr(rk[i-1], 3) ^ rk[i-3];
      tmp   = tmp ^ rotr(tmp, 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {63'd0, zseq[(i-4)%62]} ^ 64'd3;
    end

    tbl[0] = '{ct: CT0, pt: PT0, rnd_lat: 1'b0, spur: 1'b0};
    tbl[1] = '{ct: CT0, pt: PT0, rnd_lat: 1'b1, spur: 1'b1};
    tbl[2] = '{ct: '0,  pt: 128'd0, rnd_lat: 1'b0, spur: 1'b1};
    tbl[3] = '{ct: '0,  pt: '1, rnd_lat: 1'b1, spur: 1'b0};
    tbl[4] = '{ct: '0,  pt: 128'd1, rnd_lat: 1'b1, spur: 1'b1};
    tbl[5] = '{ct: '0,  pt: {1'b1, 127'd0}, rnd_lat: 1'b1, spur: 1'b1};
    tbl[6] = '{ct: '0,  pt: 128'h0123456789abcdef_fedcba9876543210, rnd_lat: 1'b1, spur: 1'b1};
    tbl[7] = '{ct: '0,  pt: {$urandom, $urandom, $urandom, $urandom}, rnd_lat: 1'b1, spur: 1'b1};
    for (int i = 2; i < 8; i++) tbl[i].ct = enc(tbl[i].pt);

    // reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // known-answer vector, 1-cycle key RAM: latency and key address sequence
    send_block(CT0);
    wait_output(cyc);
    chk("kat_latency", 128'(cyc), 128'd145);
    chk("kat_data", m_tdata, PT0);
    chk("kat_rd_pulses", 128'(rd_count), 128'd72);
    chk("kat_addr_seq_errs", 128'(addr_bad), 128'd0);
    chk("kat_rd_width_errs", 128'(pulse_bad), 128'd0);
    handshake("kat");

    // output back-pressure: hold m_tready low with a second block waiting
    send_block(CT0);
    wait_output(cyc);
    chk("bp_first_data", m_tdata, PT0);
    s_tdata  = tbl[2].ct;
    s_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m_tvalid !== 1'b1 || m_tdata !== PT0 || s_tready !== 1'b0) bad++;
    end
    chk("bp_hold_errs", 128'(bad), 128'd0);
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    chk("bp_tvalid_drop", 128'(m_tvalid), 128'd0);
    chk("bp_tready_after_hs", 128'(s_tready), 128'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    chk("bp_second_accepted", 128'(s_tready), 128'd0);
    wait_output(cyc);
    chk("bp_second_data", m_tdata, tbl[2].pt);
    handshake("bp_second");

    // table: latency 1-6 and stray key_data_vld pulses
    for (int i = 0; i < 8; i++) begin
      lat_rand = tbl[i].rnd_lat;
      spur_en  = tbl[i].spur;
      run_block($sformatf("tbl%0d", i), tbl[i].ct, tbl[i].pt, cyc);
    end
    lat_rand = 1'b0;
    spur_en  = 1'b0;

    // round trip through the encryption model
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(enc(pt));
      wait_output(cyc);
      checks++;
      if (m_tdata !== pt) begin
        errors++;
        $display("FAIL roundtrip%0d: got %0h expected %0h", i, m_tdata, pt);
      end
      handshake($sformatf("rt%0d", i));
    end

    // reset during WAIT at round 30; the late key return must be ignored
    @(negedge clk);
    key_invalidate = 1'b1;
    @(negedge clk);
    key_invalidate = 1'b0;
    fixed_lat = 6;
    send_block(CT0);
    bad = 1;
    for (int i = 0; i < 3000 && bad != 0; i++) begin
      @(negedge clk);
      if (key_rd_en === 1'b1 && key_addr == KAW'(30)) bad = 0;
    end
    chk("abort_reached_round30", 128'(bad), 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort_in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle_after", 128'(s_tready), 128'd1);
    chk("abort_no_output", 128'(m_tvalid), 128'd0);
    fixed_lat = 1;
    send_block(CT0);
    wait_output(cyc);
    chk("abort_latency", 128'(cyc), 128'd145);
    chk("abort_data", m_tdata, PT0);
    handshake("abort");

`ifdef SIMON_DEC_KEY_CACHE_EN
    // cached run, then refetch after invalidation
    send_block(CT0);
    wait_output(cyc);
    chk("cache_latency", 128'(cyc), 128'd73);
    chk("cache_data", m_tdata, PT0);
    chk("cache_rd_pulses", 128'(rd_count), 128'd0);
    handshake("cache");
    @(negedge clk);
    key_invalidate = 1'b1;
    @(negedge clk);
    key_invalidate = 1'b0;
    send_block(CT0);
    wait_output(cyc);
    chk("refetch_latency", 128'(cyc), 128'd145);
    chk("refetch_data", m_tdata, PT0);
    chk("refetch_rd_pulses", 128'(rd_count), 128'd72);
    handshake("refetch");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
